// File: rtl/mem_pkg.sv
// Shared types and constants for the imem boot loader.
package mem_pkg;

    localparam int IMemAddrWidth = 12;
    localparam int ChecksumWidth = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs four stream bytes into a little-endian word; the first byte lands in bits [7:0].
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        full
);

    logic [23:0] sr_q, sr_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (shift_en) begin
            sr_d  = {data, sr_q[23:8]};
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // The word includes the byte being shifted now, so it is complete in the same cycle as full.
    assign word = {data, sr_q};
    assign full = shift_en && !clear && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: unpacks a length/payload/checksum frame into imem and holds the core until it is good.
module imem_loader
    import mem_pkg::*;
#(
    parameter int AddrWidth = IMemAddrWidth,
    parameter int MaxWords  = 2**(IMemAddrWidth-2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 imem_we,
    output logic [AddrWidth-1:0] imem_addr,
    output logic [31:0]          imem_wdata,
    output logic                 core_hold,
    output logic                 done,
    output logic                 error
);

    localparam int IdxWidth = AddrWidth - 1;

    loader_state_t            state_q, state_d;
    logic [31:0]              len_q, len_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [AddrWidth-1:0]     addr_q, addr_d;
    logic [IdxWidth-1:0]      idx_q, idx_d, idx_inc;
    logic [ChecksumWidth-1:0] csum_q, csum_d;

    logic        fire, restart, pk_shift, pk_full;
    logic [31:0] pk_word;

    assign rx_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHECK);
    assign fire     = rx_valid && rx_ready;
    assign restart  = start && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
    assign pk_shift = fire && ((state_q == ST_LEN) || (state_q == ST_DATA));
    assign idx_inc  = idx_q + IdxWidth'(1);

    byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (restart),
        .shift_en (pk_shift),
        .data     (rx_data),
        .word     (pk_word),
        .full     (pk_full)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        case (state_q)
            ST_IDLE: if (restart) state_d = ST_LEN;
            ST_LEN: begin
                if (pk_full) begin
                    len_d = pk_word;
                    // Full-width compare so an oversize count cannot alias to a legal one.
                    if ((pk_word == 32'd0) || (pk_word > 32'(MaxWords))) state_d = ST_ERROR;
                    else                                                  state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fire) csum_d = csum_q ^ rx_data;
                if (pk_full) begin
                    wdata_d = pk_word;
                    addr_d  = {idx_q[AddrWidth-3:0], 2'b00};
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                idx_d   = idx_inc;
                state_d = (32'(idx_inc) == len_q) ? ST_CHECK : ST_DATA;
            end
            ST_CHECK: if (fire) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: if (restart) state_d = ST_LEN;
            default:  state_d = ST_IDLE;
        endcase
        if (restart) begin
            idx_d  = '0;
            csum_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
        end
    end

    assign imem_we    = (state_q == ST_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_hold  = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame bench for imem_loader with a frame-level model and a per-cycle write checker.
module tb_imem_loader;

    localparam int AW   = 6;
    localparam int MAXW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready, imem_we, core_hold, done, error;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    imem_loader #(.AddrWidth(AW), .MaxWords(MAXW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .error      (error)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    wr_t           exp_q[$];
    logic [7:0]    tx_q[$];
    logic [7:0]    model_cs;
    logic [AW-1:0] last_addr = '0;
    logic [31:0]   last_wdata = '0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle checker: every write must be the next one the model predicts.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("hold_when_active", 64'((rx_ready | imem_we | done | error) & ~core_hold), 64'd0);
            check("ready_low_in_write", 64'(rx_ready & imem_we), 64'd0);
            if (imem_we) begin
                check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("imem_addr", 64'(imem_addr), 64'(w.addr));
                    check("imem_wdata", 64'(imem_wdata), 64'(w.data));
                    $display("write addr=0x%0h data=0x%08h", imem_addr, imem_wdata);
                end
                last_addr  = imem_addr;
                last_wdata = imem_wdata;
            end
        end
    end

    function automatic bit legal_len(input logic [31:0] n);
        return (n != 32'd0) && (n <= 32'(MAXW));
    endfunction

    // Model: frame bytes, expected writes and outcome (1 = done, 2 = error).
    task automatic build_frame(input logic [31:0] n, input bit corrupt, input bit fixed,
                               output int exp_kind);
        logic [31:0] w;
        tx_q.delete();
        model_cs = 8'h00;
        for (int b = 0; b < 4; b++) tx_q.push_back(n[8*b +: 8]);
        if (!legal_len(n)) begin
            exp_kind = 2;
            return;
        end
        for (int k = 0; k < int'(n); k++) begin
            w = fixed ? 32'hDEADBEEF : $urandom;
            for (int b = 0; b < 4; b++) begin
                tx_q.push_back(w[8*b +: 8]);
                model_cs = model_cs ^ w[8*b +: 8];
            end
            exp_q.push_back('{addr: AW'(k * 4), data: w});
        end
        tx_q.push_back(corrupt ? (model_cs ^ 8'($urandom_range(1, 255))) : model_cs);
        exp_kind = corrupt ? 2 : 1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_to_ready", 64'(rx_ready), 64'd1);
    endtask

    task automatic send_frame(input bit gaps, input int start_at, input int nbytes,
                              output int first_edge);
        int  nb;
        bit  rdy;
        int  t;
        nb = (nbytes < 0) ? tx_q.size() : nbytes;
        first_edge = 0;
        for (int i = 0; i < nb; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    rx_valid = 1'b0;
                    rx_data  = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            rx_valid = 1'b1;
            rx_data  = tx_q[i];
            if (i == start_at) start = 1'b1;
            rdy = 1'b0;
            t = 0;
            while (!rdy) begin
                @(negedge clk);
                rdy = rx_ready;
                @(posedge clk);
                #1;
                start = 1'b0;
                if (!rdy) begin
                    t++;
                    if (t > 40) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL byte_accept: byte %0d not taken after %0d cycles, expected within 40", i, t);
                        rx_valid = 1'b0;
                        return;
                    end
                end
            end
            if (i == 0) first_edge = cyc;
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_outcome(output int kind, output int done_edge);
        kind = 0;
        done_edge = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done)  begin kind = 1; done_edge = cyc; break; end
            if (error) begin kind = 2; done_edge = cyc; break; end
        end
    endtask

    task automatic run_frame(input logic [31:0] n, input bit corrupt, input bit gaps,
                             input int start_at, input bit fixed);
        int exp_kind, kind, first, fin;
        build_frame(n, corrupt, fixed, exp_kind);
        pulse_start();
        send_frame(gaps, start_at, -1, first);
        wait_outcome(kind, fin);
        check("outcome", 64'(kind), 64'(exp_kind));
        check("writes_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        $display("frame n=0x%0h corrupt=%0d gaps=%0d outcome=%0d expected=%0d", n, corrupt, gaps, kind, exp_kind);
        if (kind == 1) begin
            if (!gaps) check("frame_cycles", 64'(fin - first), 64'(4 + 5 * int'(n)));
            @(negedge clk);
            check("hold_release", 64'(core_hold), 64'd0);
            check("done_one_cycle", 64'(done), 64'd0);
        end else if (kind == 2) begin
            repeat (3) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
                @(negedge clk);
                check("error_sticky", 64'({error, core_hold, rx_ready}), 64'b110);
            end
            rx_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, 64'({rx_ready, imem_we, core_hold, done, error}), 64'd0);
        check({tag, "_addr"}, 64'(imem_addr), 64'd0);
        check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    endtask

    initial begin
        int first;
        logic [31:0] n;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single word with known checksum.
        run_frame(32'd1, 1'b0, 1'b0, -1, 1'b1);
        check("t1_wdata", 64'(last_wdata), 64'hDEAD_BEEF);
        check("t1_addr", 64'(last_addr), 64'd0);
        check("t1_model_cs", 64'(model_cs), 64'h22);

        // Three words, gapped, start pulsed mid-payload.
        run_frame(32'd3, 1'b0, 1'b1, 6, 1'b0);
        check("t2_last_addr", 64'(last_addr), 64'd8);

        // Bad lengths, including one that would alias if truncated.
        run_frame(32'd0, 1'b0, 1'b0, -1, 1'b0);
        run_frame(32'(MAXW + 1), 1'b0, 1'b0, -1, 1'b0);
        run_frame(32'h0100_0010, 1'b0, 1'b0, -1, 1'b0);

        // Bad checksum, then recovery.
        run_frame(32'd2, 1'b1, 1'b0, -1, 1'b0);
        run_frame(32'd2, 1'b0, 1'b0, -1, 1'b0);
        check("error_cleared", 64'(error), 64'd0);

        // Reset after the second payload byte.
        begin
            int k;
            build_frame(32'd3, 1'b0, 1'b0, k);
            pulse_start();
            send_frame(1'b0, -1, 6, first);
            reset = 1'b1;
            @(posedge clk);
            #1;
            exp_q.delete();
            check_all_zero("midreset");
            reset = 1'b0;
            rx_valid = 1'b1;
            repeat (3) begin
                @(negedge clk);
                check("idle_after_reset", 64'({rx_ready, core_hold}), 64'd0);
            end
            rx_valid = 1'b0;
            @(posedge clk);
            #1;
        end

        // Full image.
        run_frame(32'(MAXW), 1'b0, 1'b0, -1, 1'b0);
        check("full_last_addr", 64'(last_addr), 64'((MAXW - 1) << 2));

        // Random frames.
        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 7))
                0:       n = 32'd0;
                1:       n = 32'(MAXW + 1) + 32'($urandom_range(0, 1000));
                default: n = 32'($urandom_range(1, MAXW));
            endcase
            run_frame(n, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
